// File: rtl/mem_if_pkg.sv
// Shared widths and FSM state encoding for the line-memory responder.
package mem_if_pkg;

    localparam int unsigned LINE_W     = 128;
    localparam int unsigned MEM_ADDR_W = 28;
    localparam int unsigned ST_W       = 2;
    localparam int unsigned CNT_W      = 8;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous write port, one asynchronous read port,
// every line cleared by reset.
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [LINE_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [LINE_W-1:0]        o_rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line memory responder: accepts one read or write in IDLE,
// waits LATENCY cycles, then pulses mem_ready for one cycle.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 64
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_op_write;
    logic              w_op_write_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [LINE_W-1:0] r_wdata;
    logic              w_accept;
    logic              w_we;
    logic [LINE_W-1:0] w_rd_line;
    logic              r_ready;
    logic [LINE_W-1:0] r_rdata;
    logic              w_unused_addr;

    // Upper address bits alias onto the same lines.
    assign w_unused_addr = ^mem_addr[MEM_ADDR_W-1:IDX_W];

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A simultaneous read+write is serviced as a write.
    assign w_op_write_nxt = w_accept ? mem_write : r_op_write;
    assign w_idx_nxt      = w_accept ? mem_addr[IDX_W-1:0] : r_idx;
    assign w_we           = (r_state == ST_RESP) && r_op_write;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op_write <= w_op_write_nxt;
            r_idx      <= w_idx_nxt;
            if (w_accept) begin
                r_wdata <= mem_wdata;
            end
            r_ready <= (w_state_nxt == ST_RESP);
            r_rdata <= ((w_state_nxt == ST_RESP) && !w_op_write_nxt) ? w_rd_line : '0;
        end
    end

    mem_line_array #(
        .DEPTH (DEPTH)
    ) u_lines (
        .i_clk   (clk),
        .i_rst   (proc_reset),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_idx_nxt),
        .o_rdata (w_rd_line)
    );

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a flat-array memory model.
module tb_mem_responder;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 64;

    typedef struct {
        logic [127:0] rdata;
        int unsigned  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic [127:0] model [DEPTH];
    exp_t         sb [$];
    exp_t         mon_e;
    int unsigned  cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           in_resp;
    bit           mon_en;
    bit           done;

    mem_responder #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one transaction from a negedge and hold it until mem_ready is seen.
    task automatic do_txn(input logic rd, input logic wr, input logic [27:0] a,
                          input logic [127:0] d, input bit scramble, input bit drop);
        exp_t        e;
        int unsigned acc;
        int          idx;
        int          n;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        acc   = cyc + (in_resp ? 2 : 1);
        idx   = int'(a % DEPTH);
        e.cyc = acc + LAT - 1;
        if (wr) begin
            model[idx] = d;
            e.rdata    = '0;
        end else begin
            e.rdata = model[idx];
        end
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_ready !== 1'b1 && cyc >= acc) begin
                if (scramble) begin
                    mem_addr  = 28'($urandom);
                    mem_wdata = rand128();
                end
                if (drop) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
            end
        end while (mem_ready !== 1'b1 && n < 60);
        in_resp = (mem_ready === 1'b1);
    endtask

    task automatic idle(input int g);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (g) @(negedge clk);
        if (g > 0) in_resp = 1'b0;
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [27:0] a;
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        in_resp    = 1'b0;
        done       = 1'b0;
        mon_en     = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 1'b1, 28'h0000005, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, 1'b0);
        idle(1);
        do_txn(1'b1, 1'b0, 28'h0000005, rand128(), 1'b0, 1'b0);
        idle(1);
        do_txn(1'b0, 1'b1, 28'h0000005, {32{4'hA}}, 1'b0, 1'b0);
        idle(2);
        do_txn(1'b1, 1'b0, 28'h0000045, rand128(), 1'b0, 1'b0);
        idle(1);
        do_txn(1'b1, 1'b1, 28'h0000003, {32{4'h5}}, 1'b0, 1'b0);
        idle(1);
        do_txn(1'b1, 1'b0, 28'h0000003, rand128(), 1'b0, 1'b0);
        do_txn(1'b1, 1'b0, 28'h0000003, rand128(), 1'b0, 1'b0);
        do_txn(1'b1, 1'b0, 28'h0000005, rand128(), 1'b0, 1'b0);
        idle(1);
        do_txn(1'b0, 1'b1, 28'h0000020, rand128(), 1'b1, 1'b0);
        idle(1);
        do_txn(1'b1, 1'b0, 28'h0000020, rand128(), 1'b1, 1'b0);
        do_txn(1'b0, 1'b1, 28'h0000011, rand128(), 1'b0, 1'b1);
        do_txn(1'b1, 1'b0, 28'h0000011, rand128(), 1'b0, 1'b1);
        idle(2);

        // Reset two cycles into a write: no pulse, no commit, storage cleared.
        mem_write  = 1'b1;
        mem_addr   = 28'h0000007;
        mem_wdata  = rand128();
        @(negedge clk);
        @(negedge clk);
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        in_resp = 1'b0;
        do_txn(1'b1, 1'b0, 28'h0000007, rand128(), 1'b0, 1'b0);
        idle(1);
        do_txn(1'b1, 1'b0, 28'h0000005, rand128(), 1'b0, 1'b0);
        idle(1);

        for (int k = 0; k < 150; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a  = ($urandom_range(0, 3) == 0) ? 28'($urandom) : 28'($urandom_range(0, 15));
            do_txn(rd, wr, a, rand128(), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0));
            idle($urandom_range(0, 2));
        end
        idle(4);
        done = 1'b1;
    end

    // Monitor: pops the scoreboard on every completion, checks idle outputs otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready cyc=%0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    total++;
                    if (mem_rdata !== mon_e.rdata) begin
                        bad++;
                        $display("FAIL rdata got=%h want=%h", mem_rdata, mon_e.rdata);
                    end
                    total++;
                    if (cyc != mon_e.cyc) begin
                        bad++;
                        $display("FAIL ready_cycle got=%0d want=%0d", cyc, mon_e.cyc);
                    end
                end
            end else begin
                total++;
                if (mem_ready !== 1'b0 || mem_rdata !== '0) begin
                    bad++;
                    $display("FAIL idle_outputs ready=%b rdata=%h want ready=0 rdata=0",
                             mem_ready, mem_rdata);
                end
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_ready cyc=%0d want_at=%0d", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
            if (done || cyc > 20000) begin
                total++;
                if (!done || sb.size() != 0) begin
                    bad++;
                    $display("FAIL end_of_run done=%0d pending=%0d want done=1 pending=0",
                             done, sb.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to mem_ready; legal range 1..255.
REQ-002 SHALL have parameter DEPTH, default 64: number of 128-bit lines stored; power of two, 2..256.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 proc_reset  input  1  asynchronous active-high reset.
REQ-006 mem_read  input  1  line read request, held by the requester until mem_ready.
REQ-007 mem_write  input  1  line write request, held by the requester until mem_ready.
REQ-008 mem_addr  input  28  line address (word address >> 2).
REQ-009 mem_wdata  input  128  write line data.
REQ-010 mem_rdata  output  128  read line data, valid only while mem_ready=1.
REQ-011 mem_ready  output  1  single-cycle completion pulse.

Function
REQ-012 Storage SHALL be DEPTH lines of 128 bits, indexed by mem_addr[log2(DEPTH)-1:0]; upper address bits are ignored (aliasing).
REQ-013 FSM states SHALL be IDLE, BUSY and RESP.
REQ-014 In IDLE, mem_read=1 or mem_write=1 at a rising edge SHALL accept the request: latch op, index and wdata, load counter with LATENCY-1, and go to BUSY (RESP if LATENCY=1).
REQ-015 If mem_read and mem_write are both 1 at acceptance, the write SHALL be serviced and the read dropped.
REQ-016 BUSY SHALL decrement the counter each cycle and go to RESP when the counter reaches 0.
REQ-017 In RESP, mem_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-018 A request accepted at edge t SHALL get mem_ready=1 in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after acceptance.
REQ-019 A read SHALL drive mem_rdata with the latched line's contents during RESP; at all other times mem_rdata SHALL be 0.
REQ-020 A write SHALL update the latched line with the latched wdata on the edge that leaves RESP.
REQ-021 Input changes during BUSY/RESP SHALL be ignored; the latched address, data and op are used.
REQ-022 A request deasserted mid-transaction SHALL still complete, including the mem_ready pulse.
REQ-023 Requests held high during RESP SHALL NOT be accepted; the earliest next acceptance is the edge after the RESP cycle.
REQ-024 Back-to-back transactions SHALL sustain one completion per LATENCY+1 cycles.
REQ-025 mem_ready SHALL be registered, with no combinational path from inputs.

Reset
REQ-026 proc_reset=1 SHALL immediately force state IDLE, counter 0, mem_ready 0 and mem_rdata 0.
REQ-027 Reset SHALL clear all storage lines to 0.
REQ-028 A transaction in flight at reset SHALL be discarded: no write commit and no mem_ready pulse.
REQ-029 The first acceptance SHALL occur at the first rising edge after reset deasserts.

Structure
REQ-030 Shared package mem_if_pkg SHALL hold LINE_W=128, MEM_ADDR_W=28 and the IDLE/BUSY/RESP state encoding.
REQ-031 Storage SHALL be a single sub-module, mem_line_array, with one synchronous write port and an asynchronous read port; the FSM and counter stay in mem_responder.

Verification (LATENCY=4, DEPTH=64)
REQ-032 Write addr 0x0000005, data 0x0123..CDEF, then read addr 0x0000005 -> each mem_ready exactly 4 cycles after acceptance, and the read returns 0x0123..CDEF.
REQ-033 Read addr 0x0000045 after writing 0xAA..AA to 0x0000005 -> returns 0xAA..AA (alias on index 5).
REQ-034 mem_read=mem_write=1, addr 0x3, wdata 0x55..55 -> a single mem_ready; a later read of 0x3 returns 0x55..55.
REQ-035 mem_read held high through mem_ready -> no second acceptance in the RESP cycle; the next mem_ready comes 5 cycles after the first.
REQ-036 proc_reset pulsed 2 cycles into a write of 0x7 -> no mem_ready, and a later read of 0x7 returns 0.
REQ-037 mem_addr and mem_wdata toggled every cycle during BUSY -> the originally latched line is written.
